// File: rtl/bridge_host_tx.sv
// bridge_host_tx: initiator side of the ASCII-hex UART register protocol.
// Serializes read/write requests as "Raaaa\r\n" / "Waaaadddd\r\n" toward a
// uart_tx and parses "Dxxxx\r\n" read responses coming back from a uart_rx.
module bridge_host_tx #(
  parameter int TIMEOUT_CLOCKS = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rw_i,
  input  logic [15:0] req_addr_i,
  input  logic [15:0] req_data_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_start_o,
  input  logic        tx_done_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i
);
  localparam int TW = $clog2(TIMEOUT_CLOCKS + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CLOCKS - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP} state_t;
  typedef enum logic [1:0] {HUNT, DIGITS, TERM} pstate_t;

  state_t        state;
  pstate_t       pstate;
  logic          lat_rw;
  logic [15:0]   lat_addr, lat_data;
  logic [3:0]    idx;
  logic [TW-1:0] timer;
  logic          hold_full;
  logic [15:0]   hold_data;
  logic [1:0]    dcnt;
  logic [15:0]   acc;
  logic [7:0]    tx_byte;
  logic          consume, last_byte, parse_done;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic is_hex(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46);
  endfunction

  function automatic logic [3:0] hex_val(input logic [7:0] c);
    return (c <= 8'h39) ? c[3:0] : (c[3:0] + 4'd9);
  endfunction

  // Frame byte selected by position; reads end early with CR LF at 5/6.
  always_comb begin
    tx_byte = 8'h0A;
    case (idx)
      4'd0:    tx_byte = lat_rw ? 8'h57 : 8'h52;
      4'd1:    tx_byte = hex_char(lat_addr[15:12]);
      4'd2:    tx_byte = hex_char(lat_addr[11:8]);
      4'd3:    tx_byte = hex_char(lat_addr[7:4]);
      4'd4:    tx_byte = hex_char(lat_addr[3:0]);
      4'd5:    tx_byte = lat_rw ? hex_char(lat_data[15:12]) : 8'h0D;
      4'd6:    tx_byte = lat_rw ? hex_char(lat_data[11:8]) : 8'h0A;
      4'd7:    tx_byte = hex_char(lat_data[7:4]);
      4'd8:    tx_byte = hex_char(lat_data[3:0]);
      4'd9:    tx_byte = 8'h0D;
      default: tx_byte = 8'h0A;
    endcase
  end

  assign tx_data_o  = tx_start_o ? tx_byte : 8'h00;
  assign consume    = tx_start_o && tx_done_i;
  assign last_byte  = (idx == (lat_rw ? 4'd10 : 4'd6));
  assign parse_done = rx_valid_i && (pstate == TERM) &&
                      (rx_data_i == 8'h0D || rx_data_i == 8'h0A);

  // Response parser: D + four uppercase hex digits + CR or LF terminator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pstate <= HUNT;
      dcnt   <= 2'd0;
      acc    <= 16'h0;
    end else if (rx_valid_i) begin
      case (pstate)
        HUNT: if (rx_data_i == 8'h44) begin
          pstate <= DIGITS;
          dcnt   <= 2'd0;
        end
        DIGITS: if (is_hex(rx_data_i)) begin
          acc  <= {acc[11:0], hex_val(rx_data_i)};
          dcnt <= dcnt + 2'd1;
          if (dcnt == 2'd3) pstate <= TERM;
        end else begin
          pstate <= HUNT;
        end
        default: pstate <= HUNT;
      endcase
    end
  end

  // Request FSM: latch, stream the frame, then wait for a response or timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_data_o  <= 16'h0;
      tx_start_o  <= 1'b0;
      idx         <= 4'd0;
      timer       <= '0;
      hold_full   <= 1'b0;
      hold_data   <= 16'h0;
      lat_rw      <= 1'b0;
      lat_addr    <= 16'h0;
      lat_data    <= 16'h0;
    end else begin
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      case (state)
        IDLE: if (req_valid_i && req_ready_o) begin
          lat_rw      <= req_rw_i;
          lat_addr    <= req_addr_i;
          lat_data    <= req_data_i;
          hold_full   <= 1'b0;
          req_ready_o <= 1'b0;
          tx_start_o  <= 1'b1;
          idx         <= 4'd0;
          state       <= SEND;
        end
        SEND: begin
          // A fast responder may finish before our LF has gone out.
          if (parse_done && !lat_rw) begin
            hold_data <= acc;
            hold_full <= 1'b1;
          end
          if (consume) begin
            if (last_byte) begin
              idx        <= 4'd0;
              tx_start_o <= 1'b0;
              timer      <= '0;
              if (lat_rw) begin
                req_ready_o <= 1'b1;
                state       <= IDLE;
              end else begin
                state <= WAIT_RSP;
              end
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        WAIT_RSP: begin
          if (parse_done || hold_full) begin
            rsp_valid_o <= 1'b1;
            rsp_data_o  <= parse_done ? acc : hold_data;
            hold_full   <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= IDLE;
          end else if (timer == TMAX) begin
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            rsp_data_o  <= 16'h0;
            req_ready_o <= 1'b1;
            state       <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bridge_host_tx.sv
// Directed bench for bridge_host_tx: expected tx bytes and responses are
// queued when stimulus is issued and popped as the DUT produces them.
module tb_bridge_host_tx;
  localparam int TO = 20;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_rw = 1'b0;
  logic [15:0] req_addr = 16'h0, req_data = 16'h0;
  logic        rsp_valid, rsp_err;
  logic [15:0] rsp_data;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done = 1'b1;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;

  int tests = 0, fails = 0;
  logic [7:0]  tx_q[$];
  logic [16:0] rsp_q[$];
  logic [15:0] rmem [0:255];

  bridge_host_tx #(.TIMEOUT_CLOCKS(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rw_i(req_rw),
    .req_addr_i(req_addr), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .tx_data_o(tx_data), .tx_start_o(tx_start), .tx_done_i(tx_done),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    string s = "0123456789ABCDEF";
    return s[n];
  endfunction

  task automatic push_frame(input logic rw, input logic [15:0] a, input logic [15:0] d);
    tx_q.push_back(rw ? 8'h57 : 8'h52);
    for (int i = 3; i >= 0; i--) tx_q.push_back(hexc(a[i*4 +: 4]));
    if (rw) for (int i = 3; i >= 0; i--) tx_q.push_back(hexc(d[i*4 +: 4]));
    tx_q.push_back(8'h0D);
    tx_q.push_back(8'h0A);
  endtask

  // Scoreboard pop: bytes consumed and response pulses, sampled on negedge.
  task automatic monitor();
    logic [8:0]  eb;
    logic [17:0] er;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (tx_start && tx_done) begin
          eb = (tx_q.size() != 0) ? {1'b0, tx_q.pop_front()} : 9'h100;
          chk("tx_byte", {23'h0, 1'b0, tx_data}, {23'h0, eb});
        end
        if (rsp_valid) begin
          er = (rsp_q.size() != 0) ? {1'b0, rsp_q.pop_front()} : 18'h20000;
          chk("rsp", {15'h0, 1'b0, rsp_err, rsp_data}, {14'h0, er});
        end
      end
    end
  endtask

  // All calls below start and end at #1 after a rising edge.
  task automatic req(input logic rw, input logic [15:0] a, input logic [15:0] d);
    int k = 0;
    while (!req_ready && k < 200) begin @(posedge clk); #1; k++; end
    chk("req_ready_wait", req_ready, 1);
    push_frame(rw, a, d);
    if (rw) rmem[a[7:0]] = d;
    req_valid = 1'b1; req_rw = rw; req_addr = a; req_data = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_last(input logic rw);
    int k = 0;
    logic found = 1'b0;
    while (!found && k < 500) begin
      @(negedge clk); k++;
      found = tx_start && tx_done && tx_data == 8'h0A;
    end
    chk("frame_end_seen", found, 1);
    @(posedge clk); #1;
    chk("tx_start_drop", tx_start, 0);
    chk("ready_after_frame", req_ready, rw);
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_d(input logic [15:0] v);
    send_rx(8'h44);
    for (int i = 3; i >= 0; i--) send_rx(hexc(v[i*4 +: 4]));
  endtask

  task automatic wait_rsp(input logic e, input logic [15:0] d);
    int k = 0;
    while (!rsp_valid && k < 200) begin @(posedge clk); #1; k++; end
    chk("rsp_seen", rsp_valid, 1);
    chk("rsp_err", rsp_err, e);
    chk("rsp_data", rsp_data, d);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
  endtask

  initial begin
    int k;
    fork
      monitor();
      begin
        #500000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1, "watchdog");
      end
    join_none

    #12 chk_reset("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Write: 57 30 30 30 35 31 32 33 34 0D 0A, no response
    req(1'b1, 16'h0005, 16'h1234);
    wait_last(1'b1);

    // Read 0x00AB answered by D00FF CR LF
    req(1'b0, 16'h00AB, 16'h0);
    wait_last(1'b0);
    rsp_q.push_back({1'b0, 16'h00FF});
    send_d(16'h00FF);
    send_rx(8'h0D);
    chk("rsp_next_cycle", rsp_valid, 1);
    chk("rsp_ff_data", rsp_data, 16'h00FF);
    chk("rsp_ff_err", rsp_err, 0);
    send_rx(8'h0A);
    chk("rsp_single_pulse", rsp_valid, 0);
    chk("rsp_data_holds", rsp_data, 16'h00FF);

    // Timeout exactly TO cycles after WAIT_RSP entry
    req(1'b0, 16'h1234, 16'h0);
    wait_last(1'b0);
    rsp_q.push_back({1'b1, 16'h0});
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!rsp_valid && k < 200);
    chk("timeout_cycles", k, TO);
    chk("timeout_err", rsp_err, 1);
    chk("timeout_data", rsp_data, 0);

    // Malformed digit dropped, next good frame accepted
    req(1'b0, 16'h0C0D, 16'h0);
    wait_last(1'b0);
    send_rx(8'h44); send_rx(8'h31); send_rx(8'h32); send_rx(8'h47); send_rx(8'h34);
    send_rx(8'h0D);
    chk("bad_frame_no_rsp", rsp_valid, 0);
    rsp_q.push_back({1'b0, 16'hBEEF});
    send_d(16'hBEEF);
    send_rx(8'h0D);
    chk("beef_valid", rsp_valid, 1);
    chk("beef_data", rsp_data, 16'hBEEF);
    send_rx(8'h0A);

    // Lowercase digits are not hex: read times out
    req(1'b0, 16'h0E0F, 16'h0);
    wait_last(1'b0);
    rsp_q.push_back({1'b1, 16'h0});
    send_rx(8'h44); send_rx(8'h62); send_rx(8'h65); send_rx(8'h65); send_rx(8'h66);
    send_rx(8'h0D);
    wait_rsp(1'b1, 16'h0);

    // Unsolicited frame while idle is discarded
    @(posedge clk); #1;
    send_d(16'h1111);
    send_rx(8'h0D);
    chk("idle_discard", rsp_valid, 0);
    send_rx(8'h0A);

    // Frame arriving during a write is discarded
    tx_done = 1'b0;
    req(1'b1, 16'h0010, 16'hBEAD);
    send_d(16'h2222); send_rx(8'h0D); send_rx(8'h0A);
    tx_done = 1'b1;
    wait_last(1'b1);
    repeat (TO + 5) @(posedge clk);
    #1 chk("write_discard_idle", req_ready, 1);

    // Response overtakes final LF: held, reported right after WAIT_RSP entry
    tx_done = 1'b0;
    req(1'b0, 16'h00C1, 16'h0);
    send_d(16'hCAFE); send_rx(8'h0D); send_rx(8'h0A);
    tx_done = 1'b1;
    rsp_q.push_back({1'b0, 16'hCAFE});
    wait_last(1'b0);
    @(posedge clk); #1;
    chk("hold_valid", rsp_valid, 1);
    chk("hold_data", rsp_data, 16'hCAFE);

    // Remote register model: write then read back
    req(1'b1, 16'h0042, 16'hA5C3);
    wait_last(1'b1);
    req(1'b0, 16'h0042, 16'h0);
    wait_last(1'b0);
    rsp_q.push_back({1'b0, rmem[8'h42]});
    send_d(rmem[8'h42]); send_rx(8'h0D);
    chk("remote_valid", rsp_valid, 1);
    chk("remote_data", rsp_data, 16'hA5C3);
    send_rx(8'h0A);

    // Reset during the 3rd tx byte
    req(1'b1, 16'h0077, 16'h1357);
    repeat (3) @(negedge clk);
    chk("third_byte", tx_data, 8'h30);
    #1 rst_n = 1'b0;
    #1 chk_reset("rst_tx");
    tx_q.delete(); rsp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    req(1'b1, 16'h0077, 16'h1357);
    wait_last(1'b1);

    // Reset during WAIT_RSP, then a normal read
    req(1'b0, 16'h0078, 16'h0);
    wait_last(1'b0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset("rst_wait");
    rsp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (TO + 2) @(posedge clk);
    #1 chk("no_rsp_after_rst", rsp_valid, 0);
    req(1'b0, 16'h0078, 16'h0);
    wait_last(1'b0);
    rsp_q.push_back({1'b0, 16'h4321});
    send_d(16'h4321); send_rx(8'h0D); send_rx(8'h0A);
    repeat (3) @(posedge clk);
    #1 chk("post_rst_data", rsp_data, 16'h4321);

    chk("tx_q_drained", tx_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bridge_host_tx.md
Name: bridge_host_tx

Overview:
- FPGA-side initiator for the ASCII-hex UART bus protocol; the mirror of the command-decode / response-encode bridge pair.
- Accepts 16-bit register read/write requests from local logic and serializes them into "Raaaa\r\n" or "Waaaadddd\r\n" byte streams toward a uart_tx.
- Parses "Dxxxx\r\n" read responses arriving from a uart_rx.
- Lets one board drive the register cores of another board over a single serial link.

Parameters:
- TIMEOUT_CLOCKS, 65535: clk cycles allowed in WAIT_RSP before a read is failed. Minimum 1. The counter width is $clog2(TIMEOUT_CLOCKS+1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  request strobe
- req_ready_o  out  1  block can accept a request
- req_rw_i  in  1  1 = write, 0 = read
- req_addr_i  in  16  target address
- req_data_i  in  16  write data (ignored for reads)
- rsp_valid_o  out  1  one-cycle pulse: read finished
- rsp_data_o  out  16  read data; 0 on error
- rsp_err_o  out  1  qualifies rsp_valid_o: read timed out
- tx_data_o  out  8  byte to transmit
- tx_start_o  out  1  tx_data_o is valid and requested
- tx_done_i  in  1  uart_tx idle/ready
- rx_data_i  in  8  received byte
- rx_valid_i  in  1  one-cycle pulse: rx_data_i valid

Behaviour:
- Reset (async, rst_n low): state IDLE; req_ready_o=1; rsp_valid_o=0; rsp_err_o=0; rsp_data_o=0; tx_start_o=0; tx_data_o=0; parser in HUNT; hold register empty; all counters 0.
- Reset asserted mid-transaction aborts it. No partial bytes are resent. After release the block is in IDLE.
- Request handshake:
  - A request is accepted on a cycle with req_valid_i && req_ready_o.
  - On acceptance, rw/addr/data are latched and req_ready_o drops the next cycle.
  - req_valid_i is ignored while req_ready_o=0.
- States:
  - IDLE: waits for a request. Clears the hold register on acceptance. Goes to SEND.
  - SEND:
    - tx_start_o=1. tx_data_o is driven combinationally from the byte index and the latched fields.
    - A byte is consumed on any cycle with tx_start_o && tx_done_i; the index increments.
    - Read frame, 7 bytes: 0x52, 4 address hex digits MSB first, 0x0D, 0x0A.
    - Write frame, 11 bytes: 0x57, 4 address digits, 4 data digits, 0x0D, 0x0A.
    - Hex digits are uppercase ASCII (0x30-0x39, 0x41-0x46).
    - When the final byte is consumed, tx_start_o drops the next cycle and the index resets. A write returns to IDLE with req_ready_o=1 and produces no rsp pulse. A read goes to WAIT_RSP with the timeout counter at 0.
  - WAIT_RSP:
    - If the hold register is full, pulse rsp_valid_o with the held data and go to IDLE.
    - Otherwise the timeout counter increments each cycle. When it reaches TIMEOUT_CLOCKS, pulse rsp_valid_o with rsp_err_o=1 and rsp_data_o=0, then go to IDLE.
    - If a valid parse and the timeout land on the same cycle, the parse wins.
- rsp_valid_o and rsp_err_o are single-cycle pulses. rsp_data_o holds until the next response.
- Response parser (runs in every state, one byte per rx_valid_i):
  - HUNT: 0x44 ('D') goes to DIGITS with count 0. Any other byte is ignored.
  - DIGITS: a hex digit shifts into a 16-bit accumulator MSB first. After the 4th digit, go to TERM. A non-hex byte (including lowercase) returns to HUNT with no response.
  - TERM: 0x0D or 0x0A marks a complete parse and returns to HUNT. Any other byte returns to HUNT with no response.
  - The trailing LF of a "\r\n" pair is absorbed by HUNT.
- Completed-parse routing:
  - Outstanding read in SEND (response overtakes the final LF): store in the 1-deep hold register.
  - In WAIT_RSP: complete immediately, with rsp_valid_o asserted the cycle after the terminator byte.
  - In IDLE, or during a write: discard.
  - A second parse while the hold register is full overwrites it.

Test Plan:
- Write addr 0x0005 data 0x1234, tx_done_i tied 1 -> 11 consumed bytes 57 30 30 30 35 31 32 33 34 0D 0A in order; no rsp_valid_o; req_ready_o returns 1 the cycle after the LF is consumed.
- Read addr 0x00AB, then inject rx "D00FF\r\n" after the LF is consumed -> tx bytes 52 30 30 41 42 0D 0A; a single rsp_valid_o with rsp_data_o=0x00FF, rsp_err_o=0.
- Read with TIMEOUT_CLOCKS=20 and no rx traffic -> rsp_valid_o and rsp_err_o pulse together exactly 20 cycles after WAIT_RSP entry; rsp_data_o=0.
- Read, inject "D12G4\r" then "DBEEF\r\n" -> the first frame is dropped; rsp_data_o=0xBEEF, err 0. Also inject "Dbeef\r" alone -> timeout.
- Loop back tx through a uart_tx -> uart_rx -> bridge_rx, and reply from bridge_tx with a register core -> a write followed by a read of the same address returns the written value.
- Pulse rst_n low during the 3rd tx byte, and separately during WAIT_RSP -> all outputs at reset values asynchronously; a new request after release completes normally.
